rsa_exp_ctrl: RTL



---
 rtl/rsa_pkg.sv | 29 ++
 rtl/rsa_prep.sv | 65 ++++++
 rtl/rsa_exp_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// ============================================================================
// Module   : rsa_pkg
// Purpose  : Shared widths, iteration counts and FSM encoding for the RSA
//            modular-exponentiation controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rsa_pkg;

  localparam int RSA_WIDTH  = 256;
  localparam int PREP_ITERS = 256;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    PREP      = 4'd1,
    BIT       = 4'd2,
    MUL_ISSUE = 4'd3,
    MUL_GUARD = 4'd4,
    MUL_WAIT  = 4'd5,
    SQR_ISSUE = 4'd6,
    SQR_GUARD = 4'd7,
    SQR_WAIT  = 4'd8,
    DONE      = 4'd9
  } rsa_state_t;

endpackage

`default_nettype wire

// File: rtl/rsa_prep.sv
// ============================================================================
// Module   : rsa_prep
// Purpose  : Modular-doubling engine, one doubling per cycle, producing
//            y * 2^PREP_ITERS mod n (the Montgomery form of y).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rsa_prep
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] t
);

  localparam int CW = $clog2(PREP_ITERS);
  localparam logic [CW-1:0] c_last = CW'(PREP_ITERS - 1);

  logic [WIDTH-1:0] r_t;
  logic [WIDTH-1:0] r_n;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_dbl;
  logic             w_ge;

  // 2t - n stays below n, so the subtraction can be done modulo 2^WIDTH.
  assign w_dbl = {r_t[WIDTH-2:0], 1'b0};
  assign w_ge  = {r_t, 1'b0} >= {1'b0, r_n};
  assign t     = r_t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t   <= '0;
      r_n   <= '0;
      r_cnt <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        r_t   <= y;
        r_n   <= n;
        r_cnt <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        r_t   <= w_ge ? (w_dbl - r_n) : w_dbl;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == c_last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rsa_exp_ctrl.sv
// ============================================================================
// Module   : rsa_exp_ctrl
// Purpose  : Right-to-left Montgomery square-and-multiply controller driving
//            one external Montgomery multiplier. Option macro:
//            RSA_EXP_EARLY_EXIT_EN stops once no exponent bits remain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rsa_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] n_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] m_o,
  output logic             mm_start_o,
  output logic [WIDTH-1:0] mm_a_o,
  output logic [WIDTH-1:0] mm_b_o,
  output logic [WIDTH-1:0] mm_n_o,
  input  logic [WIDTH-1:0] mm_v_i,
  input  logic             mm_finish_i
);

`ifdef RSA_EXP_EARLY_EXIT_EN
  localparam bit c_early_exit = 1'b1;
`else
  localparam bit c_early_exit = 1'b0;
`endif

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] c_last_bit = IW'(WIDTH - 1);

  rsa_state_t       r_state;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_t;
  logic [WIDTH-1:0] r_m;
  logic [IW-1:0]    r_i;

  logic             w_accept;
  logic             w_prep_busy;
  logic             w_prep_done;
  logic [WIDTH-1:0] w_prep_t;
  logic             w_decide;
  logic [WIDTH-1:0] w_dec_t;
  logic [WIDTH-1:0] w_dec_d;
  rsa_state_t       w_dec_state;

  assign w_accept = ready_o & start_i & ~w_prep_busy;

  rsa_prep #(
    .WIDTH (WIDTH)
  ) u_prep (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (w_accept),
    .y     (y_i),
    .n     (n_i),
    .busy  (w_prep_busy),
    .done  (w_prep_done),
    .t     (w_prep_t)
  );

  // The BIT decision: r_d is kept right-shifted so bit i is always r_d[0].
  assign w_decide = ((r_state == PREP) && w_prep_done) ||
                    ((r_state == SQR_WAIT) && mm_finish_i && (r_i != c_last_bit));

  always_comb begin
    w_dec_t = mm_v_i;
    w_dec_d = r_d >> 1;
    if (r_state == PREP) begin
      w_dec_t = w_prep_t;
      w_dec_d = r_d;
    end
    w_dec_state = w_dec_d[0] ? MUL_ISSUE : SQR_ISSUE;
    if (c_early_exit && (w_dec_d == '0)) begin
      w_dec_state = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_n        <= '0;
      r_d        <= '0;
      r_t        <= '0;
      r_m        <= '0;
      r_i        <= '0;
      ready_o    <= 1'b1;
      done_o     <= 1'b0;
      m_o        <= '0;
      mm_start_o <= 1'b0;
      mm_a_o     <= '0;
      mm_b_o     <= '0;
      mm_n_o     <= '0;
    end else begin
      done_o     <= 1'b0;
      mm_start_o <= 1'b0;
      case (r_state)
        IDLE: begin
          ready_o <= 1'b1;
          if (w_accept) begin
            r_n     <= n_i;
            r_d     <= d_i;
            r_m     <= WIDTH'(1);
            r_t     <= '0;
            r_i     <= '0;
            ready_o <= 1'b0;
            r_state <= PREP;
          end
        end
        PREP: begin
          if (w_prep_done) begin
            r_t <= w_prep_t;
          end
        end
        MUL_ISSUE: r_state <= MUL_GUARD;
        MUL_GUARD: r_state <= MUL_WAIT;
        MUL_WAIT: begin
          if (mm_finish_i) begin
            r_m <= mm_v_i;
            if (c_early_exit && ((r_d >> 1) == '0)) begin
              r_state <= DONE;
            end else begin
              r_state    <= SQR_ISSUE;
              mm_start_o <= 1'b1;
              mm_a_o     <= r_t;
              mm_b_o     <= r_t;
              mm_n_o     <= r_n;
            end
          end
        end
        SQR_ISSUE: r_state <= SQR_GUARD;
        SQR_GUARD: r_state <= SQR_WAIT;
        SQR_WAIT: begin
          if (mm_finish_i) begin
            r_t <= mm_v_i;
            if (r_i == c_last_bit) begin
              r_state <= DONE;
            end else begin
              r_i <= r_i + 1'b1;
              r_d <= r_d >> 1;
            end
          end
        end
        DONE: begin
          done_o  <= 1'b1;
          m_o     <= r_m;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // m stays in normal form because t carries the Montgomery factor.
      if (w_decide) begin
        r_state <= w_dec_state;
        if (w_dec_state != DONE) begin
          mm_start_o <= 1'b1;
          mm_a_o     <= (w_dec_state == MUL_ISSUE) ? r_m : w_dec_t;
          mm_b_o     <= w_dec_t;
          mm_n_o     <= r_n;
        end
      end
    end
  end

endmodule

`default_nettype wire
